// File: rtl/xspi_pkg.sv
// xSPI command sequencer shared types.
// Opcodes, FSM states and the per-opcode phase descriptor.
package xspi_pkg;

  localparam logic [7:0] OP_READ   = 8'h03;
  localparam logic [7:0] OP_FREAD  = 8'h0B;
  localparam logic [7:0] OP_QOREAD = 8'h6B;
  localparam logic [7:0] OP_QIORD  = 8'hEB;
  localparam logic [7:0] OP_PP     = 8'h02;
  localparam logic [7:0] OP_QPP    = 8'h32;
  localparam logic [7:0] OP_RDSR   = 8'h05;
  localparam logic [7:0] OP_WREN   = 8'h06;
  localparam logic [7:0] OP_WRDI   = 8'h04;

  localparam logic [1:0] MODE_X1 = 2'b00;
  localparam logic [1:0] MODE_X2 = 2'b01;
  localparam logic [1:0] MODE_X4 = 2'b10;
  localparam logic [1:0] MODE_X8 = 2'b11;

  localparam logic DIR_WR = 1'b0;
  localparam logic DIR_RD = 1'b1;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA_RD,
    ST_DATA_WR,
    ST_IGNORE
  } state_e;

  typedef struct packed {
    logic [1:0] addr_mode;
    logic [3:0] dummy_cycles;
    logic [1:0] data_mode;
    logic       data_dir;
    logic       has_addr;
    logic       has_data;
    logic       valid;
  } phase_desc_t;

  function automatic phase_desc_t mk_desc(
    input logic [1:0] am,
    input logic [3:0] dc,
    input logic [1:0] dm,
    input logic       dd,
    input logic       ha,
    input logic       hd
  );
    phase_desc_t d;
    d.addr_mode    = am;
    d.dummy_cycles = dc;
    d.data_mode    = dm;
    d.data_dir     = dd;
    d.has_addr     = ha;
    d.has_data     = hd;
    d.valid        = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/xspi_cmd_decode.sv
// Opcode to phase descriptor lookup.
// Unknown opcodes yield an all-zero (invalid) descriptor.
module xspi_cmd_decode
  import xspi_pkg::*;
(
  input  logic [7:0]  op_i,
  output phase_desc_t desc_o
);

  // Table of supported NOR-flash commands
  always_comb begin
    desc_o = '0;
    case (op_i)
      OP_READ:
        desc_o = mk_desc(MODE_X1, 4'd0, MODE_X1,
                         DIR_RD, 1'b1, 1'b1);
      OP_FREAD:
        desc_o = mk_desc(MODE_X1, 4'd8, MODE_X1,
                         DIR_RD, 1'b1, 1'b1);
      OP_QOREAD:
        desc_o = mk_desc(MODE_X1, 4'd8, MODE_X4,
                         DIR_RD, 1'b1, 1'b1);
      OP_QIORD:
        desc_o = mk_desc(MODE_X4, 4'd6, MODE_X4,
                         DIR_RD, 1'b1, 1'b1);
      OP_PP:
        desc_o = mk_desc(MODE_X1, 4'd0, MODE_X1,
                         DIR_WR, 1'b1, 1'b1);
      OP_QPP:
        desc_o = mk_desc(MODE_X1, 4'd0, MODE_X4,
                         DIR_WR, 1'b1, 1'b1);
      OP_RDSR:
        desc_o = mk_desc(MODE_X1, 4'd0, MODE_X1,
                         DIR_RD, 1'b0, 1'b1);
      OP_WREN, OP_WRDI:
        desc_o = mk_desc(MODE_X1, 4'd0, MODE_X1,
                         DIR_WR, 1'b0, 1'b0);
      default: desc_o = '0;
    endcase
  end

endmodule

// File: rtl/xspi_cmd_seq.sv
// xSPI command phase sequencer (SCK domain).
// Walks opcode/address/dummy/data phases driving the PHY config.
module xspi_cmd_seq
  import xspi_pkg::*;
#(
  parameter int ADDR_BYTES       = 3,
  parameter int WORD_SIZE        = 32,
  parameter int CYCLE_COUNT_BITS = 6
) (
  input  logic                        sck_i,
  input  logic                        sce_i,
  output logic [CYCLE_COUNT_BITS-1:0] txnbc_o,
  output logic [1:0]                  txnmode_o,
  output logic                        txndir_o,
  output logic [WORD_SIZE-1:0]        txndata_o,
  input  logic [WORD_SIZE-1:0]        txndata_i,
  input  logic                        txndone_i,
  output logic [7:0]                  cmd_o,
  output logic [31:0]                 addr_o,
  output logic                        cmd_valid_o,
  input  logic [7:0]                  status_i,
  input  logic [7:0]                  rd_data_i,
  output logic                        rd_strobe_o,
  output logic [7:0]                  wr_data_o,
  output logic                        wr_valid_o
);

  localparam int CB      = CYCLE_COUNT_BITS;
  localparam int AB_BITS = 8 * ADDR_BYTES;

  localparam logic [CB-1:0] BC_BYTE = CB'(8);
  localparam logic [CB-1:0] BC_ADDR = CB'(AB_BITS);

  state_e          state_q, state_d;
  logic [CB-1:0]   bc_q, bc_d;
  logic [1:0]      mode_q, mode_d;
  logic            dir_q, dir_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [31:0]     addr_q, addr_d;
  logic [7:0]      wdat_q, wdat_d;
  logic            cvld_q, cvld_d;
  logic            wvld_q, wvld_d;
  logic            done_q;
  phase_desc_t     desc_q, desc_d;

  phase_desc_t     dcd;
  phase_desc_t     pd;
  logic            accept;

  state_e          data_st;
  state_e          post_st;
  logic [CB-1:0]   post_bc;
  logic [1:0]      post_mode;
  logic            post_dir;
  logic            no_data;
  logic            to_dummy;
  logic            to_rd;
  logic            to_wr;
  logic [7:0]      rd_byte;

  xspi_cmd_decode u_dec (
    .op_i   (txndata_i[7:0]),
    .desc_o (dcd)
  );

  if (WORD_SIZE > AB_BITS) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^txndata_i[WORD_SIZE-1:AB_BITS];
  end

  assign accept = txndone_i & ~done_q;
  assign pd     = (state_q == ST_CMD) ? dcd : desc_q;

  assign no_data  = ~pd.valid | ~pd.has_data;
  assign to_dummy = ~no_data & (pd.dummy_cycles != 4'd0);
  assign to_rd    = ~no_data & ~to_dummy & pd.data_dir;
  assign to_wr    = ~no_data & ~to_dummy & ~pd.data_dir;
  assign data_st  = pd.data_dir ? ST_DATA_RD : ST_DATA_WR;

  // Phase that follows the opcode/address: dummy, data or idle
  always_comb begin
    post_st   = ST_IGNORE;
    post_bc   = BC_BYTE;
    post_mode = MODE_X1;
    post_dir  = DIR_WR;
    unique case (1'b1)
      no_data: ;
      to_dummy: begin
        post_st   = ST_DUMMY;
        post_bc   = CB'({4'd0, pd.dummy_cycles}
                        << pd.addr_mode);
        post_mode = pd.addr_mode;
      end
      to_rd: begin
        post_st   = ST_DATA_RD;
        post_mode = pd.data_mode;
        post_dir  = DIR_RD;
      end
      to_wr: begin
        post_st   = ST_DATA_WR;
        post_mode = pd.data_mode;
      end
      default: ;
    endcase
  end

  // Next phase and its PHY config on each accepted txndone
  always_comb begin
    state_d = state_q;
    bc_d    = bc_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    desc_d  = desc_q;
    cvld_d  = 1'b0;
    wvld_d  = 1'b0;
    if (accept) begin
      unique case (state_q)
        ST_CMD: begin
          if (!pd.valid) begin
            state_d = ST_IGNORE;
            bc_d    = BC_BYTE;
            mode_d  = MODE_X1;
            dir_d   = DIR_WR;
          end else begin
            cmd_d  = txndata_i[7:0];
            desc_d = pd;
            addr_d = '0;
            if (pd.has_addr) begin
              state_d = ST_ADDR;
              bc_d    = BC_ADDR;
              mode_d  = pd.addr_mode;
              dir_d   = DIR_WR;
            end else begin
              cvld_d  = 1'b1;
              state_d = post_st;
              bc_d    = post_bc;
              mode_d  = post_mode;
              dir_d   = post_dir;
            end
          end
        end
        ST_ADDR: begin
          addr_d  = 32'(txndata_i[AB_BITS-1:0]);
          cvld_d  = 1'b1;
          state_d = post_st;
          bc_d    = post_bc;
          mode_d  = post_mode;
          dir_d   = post_dir;
        end
        ST_DUMMY: begin
          state_d = data_st;
          bc_d    = BC_BYTE;
          mode_d  = pd.data_mode;
          dir_d   = pd.data_dir;
        end
        ST_DATA_WR: begin
          wvld_d = 1'b1;
          wdat_d = txndata_i[7:0];
        end
        default: ;
      endcase
    end
  end

  // State and config registers, cleared by chip-select high-to-low
  always_ff @(posedge sck_i or negedge sce_i) begin
    if (!sce_i) begin
      state_q <= ST_CMD;
      bc_q    <= BC_BYTE;
      mode_q  <= MODE_X1;
      dir_q   <= DIR_WR;
      cmd_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      desc_q  <= '0;
      cvld_q  <= 1'b0;
      wvld_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      desc_q  <= desc_d;
      cvld_q  <= cvld_d;
      wvld_q  <= wvld_d;
      done_q  <= txndone_i;
    end
  end

  assign rd_byte = (cmd_q == OP_RDSR) ? status_i
                                      : rd_data_i;

  // Transmit word is only non-zero while returning read data
  always_comb begin
    txndata_o = '0;
    if (state_q == ST_DATA_RD)
      txndata_o = WORD_SIZE'(rd_byte);
  end

  assign rd_strobe_o = accept & (state_q == ST_DATA_RD);

  assign txnbc_o     = bc_q;
  assign txnmode_o   = mode_q;
  assign txndir_o    = dir_q;
  assign cmd_o       = cmd_q;
  assign addr_o      = addr_q;
  assign cmd_valid_o = cvld_q;
  assign wr_data_o   = wdat_q;
  assign wr_valid_o  = wvld_q;

endmodule

// File: tb/tb_xspi_cmd_seq.sv
// Self-checking bench for xspi_cmd_seq.
// Reference model is a per-opcode lane/cycle table.
module tb_xspi_cmd_seq;

  logic        sck = 1'b0;
  logic        sce_i = 1'b0;
  logic [5:0]  txnbc_o;
  logic [1:0]  txnmode_o;
  logic        txndir_o;
  logic [31:0] txndata_o;
  logic [31:0] txndata_i = '0;
  logic        txndone_i = 1'b0;
  logic [7:0]  cmd_o;
  logic [31:0] addr_o;
  logic        cmd_valid_o;
  logic [7:0]  status_i = '0;
  logic [7:0]  rd_data_i = '0;
  logic        rd_strobe_o;
  logic [7:0]  wr_data_o;
  logic        wr_valid_o;

  int n_asrt = 0;
  int n_fail = 0;
  int n_cmdv = 0;
  int n_rds  = 0;
  logic [7:0] wr_got[$];

  always #5 sck = ~sck;

  xspi_cmd_seq dut (
    .sck_i       (sck),
    .sce_i       (sce_i),
    .txnbc_o     (txnbc_o),
    .txnmode_o   (txnmode_o),
    .txndir_o    (txndir_o),
    .txndata_o   (txndata_o),
    .txndata_i   (txndata_i),
    .txndone_i   (txndone_i),
    .cmd_o       (cmd_o),
    .addr_o      (addr_o),
    .cmd_valid_o (cmd_valid_o),
    .status_i    (status_i),
    .rd_data_i   (rd_data_i),
    .rd_strobe_o (rd_strobe_o),
    .wr_data_o   (wr_data_o),
    .wr_valid_o  (wr_valid_o)
  );

  always @(negedge sck) begin
    if (cmd_valid_o === 1'b1) n_cmdv++;
    if (rd_strobe_o === 1'b1) n_rds++;
    if (wr_valid_o === 1'b1) wr_got.push_back(wr_data_o);
  end

  typedef struct packed {
    logic       known;
    logic       adr;
    logic [3:0] alanes;
    logic [3:0] dummy;
    logic [3:0] dlanes;
    logic [1:0] kind;
  } op_t;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_WR   = 2'd2;

  function automatic op_t ref_op(input logic [7:0] op);
    op_t r;
    r = '0;
    r.known = 1'b1;
    r.alanes = 4'd1;
    r.dlanes = 4'd1;
    case (op)
      8'h03: begin r.adr = 1; r.kind = K_RD; end
      8'h0B: begin
        r.adr = 1; r.dummy = 8; r.kind = K_RD;
      end
      8'h6B: begin
        r.adr = 1; r.dummy = 8; r.dlanes = 4;
        r.kind = K_RD;
      end
      8'hEB: begin
        r.adr = 1; r.alanes = 4; r.dummy = 6;
        r.dlanes = 4; r.kind = K_RD;
      end
      8'h02: begin r.adr = 1; r.kind = K_WR; end
      8'h32: begin
        r.adr = 1; r.dlanes = 4; r.kind = K_WR;
      end
      8'h05: r.kind = K_RD;
      8'h06, 8'h04: r.kind = K_NONE;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int lg(input int lanes);
    return (lanes == 4) ? 2 : (lanes == 2) ? 1 : 0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    @(negedge sck);
    chk({tag, ".bc"}, 32'(txnbc_o), 32'd8);
    chk({tag, ".mode"}, 32'(txnmode_o), 32'd0);
    chk({tag, ".dir"}, 32'(txndir_o), 32'd0);
    chk({tag, ".cmd"}, 32'(cmd_o), 32'd0);
    chk({tag, ".addr"}, addr_o, 32'd0);
    chk({tag, ".wdat"}, 32'(wr_data_o), 32'd0);
    chk({tag, ".pulses"},
        {29'd0, cmd_valid_o, wr_valid_o, rd_strobe_o},
        32'd0);
    chk({tag, ".txd"}, txndata_o, 32'd0);
  endtask

  // One PHY transaction: check config, then pulse txndone
  task automatic phase(input string tag,
                       input logic [31:0] w,
                       input int bc,
                       input int md,
                       input int dr,
                       input logic [31:0] tx,
                       input int hold);
    repeat ($urandom_range(0, 2)) begin
      @(posedge sck); #1;
    end
    @(negedge sck);
    chk({tag, ".bc"}, 32'(txnbc_o), 32'(bc));
    chk({tag, ".mode"}, 32'(txnmode_o), 32'(md));
    chk({tag, ".dir"}, 32'(txndir_o), 32'(dr));
    chk({tag, ".txd"}, txndata_o, tx);
    @(posedge sck); #1;
    txndata_i = w;
    txndone_i = 1'b1;
    repeat (hold) begin
      @(posedge sck); #1;
    end
    txndone_i = 1'b0;
  endtask

  task automatic frame(input string tag,
                       input logic [7:0] op,
                       input logic [31:0] adr,
                       input int nb,
                       input int hold);
    op_t r;
    int c0, r0, w0, am, dm;
    logic [31:0] w;
    logic [7:0] b;
    logic [7:0] wexp[$];
    r  = ref_op(op);
    c0 = n_cmdv;
    r0 = n_rds;
    w0 = wr_got.size();
    am = lg(int'(r.alanes));
    dm = lg(int'(r.dlanes));
    sce_i = 1'b0;
    @(posedge sck); #1;
    sce_i = 1'b1;
    w = $urandom;
    w[7:0] = op;
    phase({tag, ".cmd"}, w, 8, 0, 0, 0, hold);
    if (r.adr)
      phase({tag, ".addr"}, adr, 24, am, 0, 0, 1);
    if (r.dummy != 0)
      phase({tag, ".dummy"}, $urandom,
            int'(r.dummy) * int'(r.alanes),
            am, 0, 0, 1);
    for (int i = 0; i < nb; i++) begin
      if (r.kind == K_RD) begin
        b = (op == 8'h05) ? status_i : rd_data_i;
        phase({tag, ".rd"}, $urandom, 8, dm, 1,
              {24'd0, b}, 1);
        rd_data_i = ~rd_data_i;
      end else if (r.kind == K_WR) begin
        b = 8'($urandom);
        wexp.push_back(b);
        w = $urandom;
        w[7:0] = b;
        phase({tag, ".wr"}, w, 8, dm, 0, 0, 1);
      end else begin
        phase({tag, ".ign"}, $urandom, 8, 0, 0, 0, 1);
      end
    end
    @(negedge sck); #1;
    chk({tag, ".ncmdv"}, 32'(n_cmdv - c0),
        r.known ? 32'd1 : 32'd0);
    chk({tag, ".cmd_o"}, 32'(cmd_o),
        r.known ? {24'd0, op} : 32'd0);
    chk({tag, ".addr_o"}, addr_o,
        r.adr ? {8'd0, adr[23:0]} : 32'd0);
    chk({tag, ".nrd"}, 32'(n_rds - r0),
        (r.kind == K_RD) ? 32'(nb) : 32'd0);
    chk({tag, ".nwr"}, 32'(wr_got.size() - w0),
        32'(wexp.size()));
    foreach (wexp[i])
      if (w0 + i < wr_got.size())
        chk({tag, ".wdat"}, 32'(wr_got[w0 + i]),
            32'(wexp[i]));
  endtask

  logic [7:0] ops[10] = '{8'h03, 8'h0B, 8'h6B, 8'hEB,
                          8'h02, 8'h32, 8'h05, 8'h06,
                          8'h04, 8'h9F};

  initial begin
    int c0;
    logic [7:0] op;
    chk_reset("reset");
    @(posedge sck); #1;

    rd_data_i = 8'hA5;
    frame("t1_read", 8'h03, 32'h00123456, 4, 1);

    rd_data_i = 8'h3C;
    frame("t2_qio", 8'hEB, 32'h0000ABCD, 3, 1);

    frame("t3_pp", 8'h02, 32'h0, 3, 1);

    status_i = 8'h03;
    frame("t4_rdsr", 8'h05, 32'h0, 2, 1);

    frame("t5_ign", 8'hFF, 32'h0, 3, 1);

    c0 = n_cmdv;
    sce_i = 1'b0;
    @(posedge sck); #1;
    sce_i = 1'b1;
    phase("t6.cmd", 32'h03, 8, 0, 0, 0, 1);
    repeat (3) begin
      @(posedge sck); #1;
    end
    txndata_i = 32'h00000456;
    sce_i = 1'b0;
    chk_reset("t6_midrst");
    @(negedge sck); #1;
    chk("t6.nopulse", 32'(n_cmdv - c0), 32'd0);
    frame("t6_wren", 8'h06, 32'h0, 0, 1);

    rd_data_i = 8'h81;
    frame("hold2", 8'h0B, 32'h00FEDCBA, 2, 2);

    for (int k = 0; k < 10; k++) begin
      op = ops[$urandom_range(0, 9)];
      rd_data_i = 8'($urandom);
      status_i = 8'($urandom);
      frame("rnd", op, $urandom, $urandom_range(1, 4), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
